// File: rtl/fabric_add_arb_if.sv
// Bundle of requester-side and fabric-side signals for the fabric add arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
interface fabric_add_arb_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned TW = 2;
    localparam int unsigned NW = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 12;
    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [TW*NREQ-1:0] req_type;
    logic [NW*NREQ-1:0] req_dst_nid;
    logic [AW*NREQ-1:0] req_addr;
    logic [DW*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_mask;
    logic               fabric_add_ready;
    logic               fabric_add_valid;
    logic [TW-1:0]      fabric_add_type;
    logic [NW-1:0]      fabric_add_dst_nid;
    logic [AW-1:0]      fabric_add_addr;
    logic [DW-1:0]      fabric_add_data;
    logic [GW-1:0]      arb_last_grant;

    modport slave (
        input  req_valid, req_type, req_dst_nid, req_addr, req_data, req_mask,
        input  fabric_add_ready,
        output req_ready, fabric_add_valid, fabric_add_type, fabric_add_dst_nid,
        output fabric_add_addr, fabric_add_data, arb_last_grant
    );

    modport master (
        output req_valid, req_type, req_dst_nid, req_addr, req_data, req_mask,
        output fabric_add_ready,
        input  req_ready, fabric_add_valid, fabric_add_type, fabric_add_dst_nid,
        input  fabric_add_addr, fabric_add_data, arb_last_grant
    );
endinterface

// File: rtl/fabric_add_arb.sv
// Round-robin arbiter folding NREQ requesters into one registered fabric add slot.
// The slot may drain and refill in the same cycle, giving one packet per cycle.
module fabric_add_arb #(
    parameter int unsigned NREQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    fabric_add_arb_if.slave  bus
);
    localparam int unsigned TW = 2;
    localparam int unsigned NW = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 12;
    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    typedef struct packed {
        logic [TW-1:0] ptype;
        logic [NW-1:0] nid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } pkt_t;

    state_t          r_state;
    state_t          w_state_nxt;
    pkt_t            r_pkt;
    pkt_t            w_sel_pkt;
    logic [GW-1:0]   r_last_grant;
    logic [GW-1:0]   w_grant_idx;
    logic            w_grant_vld;
    logic            w_slot_free;
    logic            w_capture;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_req_ready;

    assign w_elig      = bus.req_valid & ~bus.req_mask;
    assign w_slot_free = (r_state == S_EMPTY) || bus.fabric_add_ready;
    assign w_capture   = |(bus.req_valid & w_req_ready);

    // First eligible requester, starting one past the last grant and wrapping
    always_comb begin
        int unsigned cand;
        cand        = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = r_last_grant;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(r_last_grant) + i + 1) % NREQ;
            if (!w_grant_vld && w_elig[GW'(cand)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = GW'(cand);
            end
        end
    end

    assign w_sel_pkt.ptype = bus.req_type[w_grant_idx*TW +: TW];
    assign w_sel_pkt.nid   = bus.req_dst_nid[w_grant_idx*NW +: NW];
    assign w_sel_pkt.addr  = bus.req_addr[w_grant_idx*AW +: AW];
    assign w_sel_pkt.data  = bus.req_data[w_grant_idx*DW +: DW];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_capture) w_state_nxt = S_FULL;
            S_FULL: begin
                if (w_capture) begin
                    w_state_nxt = S_FULL;
                end else if (bus.fabric_add_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Accept is suppressed throughout reset so nothing is handed over mid-reset
    always_comb begin
        w_req_ready = '0;
        if (!reset && w_slot_free && w_grant_vld) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt        <= '0;
            r_last_grant <= GW'(NREQ - 1);
        end else if (w_capture) begin
            r_pkt        <= w_sel_pkt;
            r_last_grant <= w_grant_idx;
        end
    end

    assign bus.req_ready          = w_req_ready;
    assign bus.fabric_add_valid   = (r_state == S_FULL);
    assign bus.fabric_add_type    = r_pkt.ptype;
    assign bus.fabric_add_dst_nid = r_pkt.nid;
    assign bus.fabric_add_addr    = r_pkt.addr;
    assign bus.fabric_add_data    = r_pkt.data;
    assign bus.arb_last_grant     = r_last_grant;
endmodule

// File: doc/fabric_add_arb.md
FABRIC_ADD_ARB -- requirements
Module: fabric_add_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one fabric add port; 4 is the only configuration built and verified.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  4  per-requester packet offer; bit i belongs to requester i.
REQ-005 req_type  input  8  packed 2-bit type; bits [2i+1:2i] belong to requester i.
REQ-006 req_dst_nid  input  16  packed 4-bit destination node id, requester i at [4i+3:4i].
REQ-007 req_addr  input  48  packed 12-bit address, requester i at [12i+11:12i].
REQ-008 req_data  input  48  packed 12-bit data, requester i at [12i+11:12i].
REQ-009 req_ready  output  4  one-hot (or zero) accept per requester.
REQ-010 req_mask  input  4  configuration; bit i = 1 excludes requester i from arbitration.
REQ-011 fabric_add_ready  input  1  fabric accepts the presented packet this cycle.
REQ-012 fabric_add_valid  output  1  packet presented to fabric.
REQ-013 fabric_add_type / fabric_add_dst_nid / fabric_add_addr / fabric_add_data  output  2/4/12/12  presented packet fields.
REQ-014 arb_last_grant  output  2  index of the most recently captured requester.

Function
REQ-015 The block SHALL hold one packet in an output register; it is in state EMPTY (fabric_add_valid=0) or FULL (fabric_add_valid=1).
REQ-016 Slot is free when EMPTY, or when FULL and fabric_add_ready=1 (drain and refill in the same cycle allowed).
REQ-017 Eligible set = req_valid & ~req_mask; when the slot is free and the eligible set is non-empty, exactly one req_ready bit SHALL be 1.
REQ-018 Winner is the first eligible index, searching (arb_last_grant+1) mod 4 upward with wrap.
REQ-019 When the slot is not free or no requester is eligible, req_ready SHALL be 0000.
REQ-020 req_ready SHALL be combinational from the current state and inputs, with no dependence on req_ready itself.
REQ-021 On req_valid[i] & req_ready[i], requester i's fields are captured into the output register on the next edge, fabric_add_valid=1 and arb_last_grant=i; transfer latency is 1 cycle.
REQ-022 While FULL and fabric_add_ready=0, all fabric_add_* outputs SHALL stay stable.
REQ-023 FULL with fabric_add_ready=1 and no capture leads to EMPTY; FULL with ready and capture stays FULL with the new packet.
REQ-024 arb_last_grant SHALL change only on a capture.
REQ-025 A mask change takes effect the same cycle; masking a requester never drops a packet already held.
REQ-026 A requester whose req_valid is deasserted without a handshake is ignored; no state changes.
REQ-027 With all four requesters continuously valid and unmasked, and fabric_add_ready=1, grants SHALL follow 0,1,2,3,0,... with one packet per cycle.
REQ-028 Fairness: a continuously valid, unmasked requester SHALL be granted within 4 captures.

Reset
REQ-029 On reset, in the same cycle as the edge: fabric_add_valid=0 and all fabric_add_* fields = 0.
REQ-030 On reset, arb_last_grant=3, so requester 0 has first priority.
REQ-031 req_ready SHALL be 0000 in any cycle where reset=1.
REQ-032 Reset during FULL SHALL discard the held packet without a fabric handshake.

Verification
REQ-033 After reset, req_valid=0101 and fabric_add_ready=1 -> cycle 0 req_ready=0001; cycle 1 fabric_add_valid=1, addr=requester 0's value, req_ready=0100.
REQ-034 Hold fabric_add_ready=0 for 5 cycles with a packet held (type=2, nid=0xA, addr=0x123, data=0xABC) -> outputs constant, req_ready=0000 throughout; on ready=1 the next packet loads the following cycle.
REQ-035 All four valid, ready=1 for 8 cycles -> arb_last_grant sequence 0,1,2,3,0,1,2,3 with no idle cycle.
REQ-036 req_mask=0010 with req_valid=1111 -> requester 1 is never granted; order is 0,2,3,0.
REQ-037 Assert reset while FULL with ready=0 -> next cycle valid=0, fields=0, arb_last_grant=3; the first grant after reset goes to the lowest eligible index.
REQ-038 Requester 2 is the only valid requester and drops req_valid while the slot is not free -> no capture occurs and arb_last_grant is unchanged.
